des_key_schedule: RTL
=====================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request to begin a 16-key schedule; accepted only in IDLE.
REQ-005 key_in  input  64  DES key; bits 56,48,...,0 (parity bits, DES bit 8k) are ignored.
REQ-006 decrypt  input  1  key order select, sampled with start; present only when the macro in REQ-027 is defined.
REQ-007 key_ready  input  1  downstream round stage consumes the current round_key this cycle.
REQ-008 round_key  output  48  PC-2 subkey for the current round, MSB = DES bit 1.
REQ-009 round_num  output  4  index of the round that consumes round_key: 0..15.
REQ-010 key_valid  output  1  round_key and round_num are valid.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the 16th key is accepted.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE when key_valid & key_ready & round_num=15.
- DONE -> IDLE unconditionally after one cycle.
REQ-014 On start in IDLE, the C and D registers (28 bits each) SHALL load PC-1(key_in), pre-rotated for the first key.
- Encrypt: left-rotated by 1.
- Decrypt: not rotated.
REQ-015 key_valid SHALL be 1 exactly in RUN, with the first key presented the cycle after start (latency 1).
REQ-016 round_key SHALL be registered, equal PC-2(C,D), and change only when a key is accepted (key_valid & key_ready) or a new schedule loads.
REQ-017 With key_valid=1 and key_ready=0, round_key, round_num and C/D SHALL hold for any number of cycles.
REQ-018 On acceptance in encrypt mode, C and D SHALL left-rotate by the shift count of the next key.
- Shift 1 for keys 1, 2, 9 and 16.
- Shift 2 for all other keys.
REQ-019 On acceptance in decrypt mode, C and D SHALL right-rotate by the next entry of the sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, producing keys K16..K1 in order.
REQ-020 round_num SHALL count 0..15 and increment on each acceptance; it never wraps inside a schedule and resets to 0 in DONE.
REQ-021 start asserted in RUN or DONE SHALL be ignored, with no effect on the current schedule.
REQ-022 start asserted in the same cycle done is high SHALL be ignored; a new schedule starts no earlier than the IDLE cycle.
REQ-023 key_in and decrypt SHALL be sampled only on the accepted start cycle; later changes SHALL not affect the schedule.
REQ-024 Throughput with key_ready held at 1 SHALL be 16 keys in 16 consecutive cycles, then done, then IDLE: 18 cycles from start to the next start accepted.

Reset
REQ-025 With rst_n=0 at a rising clk, the block SHALL enter IDLE and clear outputs and registers:
- round_key=0, round_num=0, key_valid=0, busy=0, done=0.
- C=0, D=0, stored mode=encrypt.
REQ-026 Reset asserted mid-schedule SHALL abort the schedule with no done pulse; the first post-reset key appears only after a new start.

Configuration
REQ-027 Macro DES_KEYSCHED_DECRYPT_EN SHALL control decrypt support.
- Defined: the decrypt port exists and REQ-019 applies.
- Undefined: the decrypt port is absent, and the block always produces encrypt order K1..K16 with right-rotation logic removed.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Encrypt, key_in=133457799BBCDFF1, key_ready=1: round 0 key = 1B02EFFC7072; round 15 key = CB3D8B0E17F5; done in cycle 17 after start.
- Decrypt (macro defined), same key: round 0 key = CB3D8B0E17F5; round 15 key = 1B02EFFC7072.
- Back-pressure: key_ready=0 for 5 cycles at round_num=3 -> round_key and round_num stable for those 5 cycles; all 16 keys still match the reference model.
- start pulsed at round_num=7 with a different key_in -> ignored; remaining keys belong to the original key.
- rst_n=0 at round_num=9 -> next cycle all outputs 0 and busy=0; no done; a new start gives round 0 key = 1B02EFFC7072.
- Parity bits flipped: key_in=123456789ABCDEF0 XOR 0101010101010101 -> all 16 keys identical to those for the unflipped key.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit DES key into the 16 48-bit round keys.
// Keys are streamed one per accepted handshake (key_valid & key_ready), with
// round_num naming the round that consumes the current key.
// Optional feature macro: DES_KEYSCHED_DECRYPT_EN adds the decrypt port and
// the right-rotating path that emits K16..K1. Without it only K1..K16 exist.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
`ifdef DES_KEYSCHED_DECRYPT_EN
    input  logic        decrypt,
`endif
    input  logic        key_ready,
    output logic [47:0] round_key,
    output logic [3:0]  round_num,
    output logic        key_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Permuted choice tables, DES bit numbering (1 = MSB).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = 56'd0;
        for (int i = 0; i < 56; i++) begin
            o[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = 48'd0;
        for (int i = 0; i < 48; i++) begin
            o[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return o;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
        logic [27:0] r;
        if (one) begin
            r = {x[26:0], x[27]};
        end else begin
            r = {x[25:0], x[27:26]};
        end
        return r;
    endfunction

`ifdef DES_KEYSCHED_DECRYPT_EN
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
        logic [27:0] r;
        if (one) begin
            r = {x[0], x[27:1]};
        end else begin
            r = {x[1:0], x[27:2]};
        end
        return r;
    endfunction

    logic        r_decrypt;
`endif

    logic [1:0]  r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [47:0] r_round_key;
    logic [3:0]  r_round_num;
    logic        r_key_valid;
    logic        r_busy;
    logic        r_done;

    logic [55:0] w_pc1;
    logic [27:0] w_c_load;
    logic [27:0] w_d_load;
    logic [27:0] w_c_next;
    logic [27:0] w_d_next;
    logic        w_shift_one;
    logic        w_accept;

    assign w_pc1    = pc1(key_in);
    assign w_accept = r_key_valid & key_ready;
    // Encrypt shifts 1,1,2,..: the step after rounds 0, 7 and 14 is a single
    // rotate. The decrypt sequence 1,2,2,2,2,2,2,1,... lands on the same rounds.
    assign w_shift_one = (r_round_num == 4'd0) || (r_round_num == 4'd7) ||
                         (r_round_num == 4'd14);

    // Load value for C/D on start and the rotated value for the next round.
    always_comb begin
        w_c_load = rotl28(w_pc1[55:28], 1'b1);
        w_d_load = rotl28(w_pc1[27:0], 1'b1);
        w_c_next = rotl28(r_c, w_shift_one);
        w_d_next = rotl28(r_d, w_shift_one);
`ifdef DES_KEYSCHED_DECRYPT_EN
        // Decrypt starts from C0/D0 itself, which equals C16/D16.
        if (decrypt) begin
            w_c_load = w_pc1[55:28];
            w_d_load = w_pc1[27:0];
        end else begin
            w_c_load = rotl28(w_pc1[55:28], 1'b1);
            w_d_load = rotl28(w_pc1[27:0], 1'b1);
        end
        if (r_decrypt) begin
            w_c_next = rotr28(r_c, w_shift_one);
            w_d_next = rotr28(r_d, w_shift_one);
        end else begin
            w_c_next = rotl28(r_c, w_shift_one);
            w_d_next = rotl28(r_d, w_shift_one);
        end
`endif
    end

    // Control FSM plus C/D and registered round key / status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_c         <= 28'd0;
            r_d         <= 28'd0;
            r_round_key <= 48'd0;
            r_round_num <= 4'd0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
            r_decrypt   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_RUN;
                        r_c         <= w_c_load;
                        r_d         <= w_d_load;
                        r_round_key <= pc2({w_c_load, w_d_load});
                        r_round_num <= 4'd0;
                        r_key_valid <= 1'b1;
                        r_busy      <= 1'b1;
`ifdef DES_KEYSCHED_DECRYPT_EN
                        r_decrypt   <= decrypt;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_accept && (r_round_num == 4'd15)) begin
                        // Last key consumed; key/C/D hold, counter parks at 0.
                        r_state     <= S_DONE;
                        r_round_num <= 4'd0;
                        r_key_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (w_accept) begin
                        r_c         <= w_c_next;
                        r_d         <= w_d_next;
                        r_round_key <= pc2({w_c_next, w_d_next});
                        r_round_num <= r_round_num + 4'd1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_key_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign round_key = r_round_key;
    assign round_num = r_round_num;
    assign key_valid = r_key_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
